exec_muldiv: RTL and testbench



---
 rtl/rv32i_types.sv | 29 ++
 rtl/restoring_divider.sv | 50 +++++
 rtl/exec_muldiv.sv | 161 ++++++++++++++++
 tb/tb_exec_muldiv.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared RV32 type definitions; this slice carries the M-extension execute unit types.
package rv32i_types;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } muldiv_state_t;

  localparam logic [6:0] m_extension = 7'b0000001;

  // funct3[2] separates the multiply group from the divide group.
  function automatic logic op_is_mul(input logic [2:0] op);
    return ~op[2];
  endfunction

endpackage

// File: rtl/restoring_divider.sv
// Iterative restoring divider datapath: one quotient bit per step on operand
// magnitudes, with sign correction applied to the values produced by each step.
module restoring_divider #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            start_i,
  input  logic            step_i,
  input  logic            signed_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] quo_o,
  output logic [XLEN-1:0] rem_o
);

  logic            a_neg, b_neg;
  logic [XLEN-1:0] rem_q, quo_q, dvs_q;
  logic            negq_q, negr_q;
  logic [XLEN:0]   shifted, diff;
  logic [XLEN-1:0] rem_n, quo_n;

  assign a_neg = signed_i & a_i[XLEN-1];
  assign b_neg = signed_i & b_i[XLEN-1];

  // Pure datapath: contents only matter after a start, so no reset.
  always_ff @(posedge clk) begin
    if (start_i) begin
      rem_q  <= '0;
      quo_q  <= a_neg ? -a_i : a_i;
      dvs_q  <= b_neg ? -b_i : b_i;
      negq_q <= a_neg ^ b_neg;
      negr_q <= a_neg;
    end else if (step_i) begin
      rem_q <= rem_n;
      quo_q <= quo_n;
    end
  end

  // The dividend is shifted out of the quotient register MSB-first while
  // quotient bits shift in at the bottom.
  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    diff    = shifted - {1'b0, dvs_q};
    rem_n   = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
    quo_n   = {quo_q[XLEN-2:0], ~diff[XLEN]};
    quo_o   = negq_q ? -quo_n : quo_n;
    rem_o   = negr_q ? -rem_n : rem_n;
  end

endmodule

// File: rtl/exec_muldiv.sv
// RV32M multi-cycle execute unit: fixed-latency multiplier and iterative divider
// behind a single-request FSM with a valid/ready result port and flush abort.
module exec_muldiv
  import rv32i_types::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  input  logic [4:0]      req_rd_s,
  input  logic            flush,
  output logic            busy,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_result,
  output logic [4:0]      resp_rd_s
);

  localparam int CNT_W = $clog2(XLEN + 1);

  muldiv_state_t   state_q;
  logic [CNT_W-1:0] count_q;
  logic            resp_valid_q;
  logic [XLEN-1:0] resp_result_q;
  logic [4:0]      resp_rd_q;

  logic [1:0]      op_q;
  logic [XLEN-1:0] a_q, b_q;

  logic            accept;
  logic            div_zero, div_ovf, div_special;
  logic [XLEN-1:0] special_res;

  logic [1:0]      mop;
  logic [XLEN-1:0] ma, mb, mul_res;
  logic            a_sx, b_sx;
  logic [2*XLEN-1:0] ma_ext, mb_ext, mprod;

  logic [XLEN-1:0] div_quo, div_rem;

  assign req_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign resp_valid  = resp_valid_q;
  assign resp_result = resp_result_q;
  assign resp_rd_s   = resp_rd_q;

  assign accept = req_valid & req_ready & ~flush;

  // Multiplier reads the request directly when the product is needed at accept
  // time (single-stage case) and the latched operands otherwise.
  always_comb begin
    mop = (state_q == ST_IDLE) ? req_op[1:0] : op_q;
    ma  = (state_q == ST_IDLE) ? req_a : a_q;
    mb  = (state_q == ST_IDLE) ? req_b : b_q;
    a_sx = (mop != 2'b11);
    b_sx = ~mop[1];
    ma_ext = {{XLEN{a_sx & ma[XLEN-1]}}, ma};
    mb_ext = {{XLEN{b_sx & mb[XLEN-1]}}, mb};
    // Truncating to 2*XLEN is exact: every signedness combination fits.
    mprod   = ma_ext * mb_ext;
    mul_res = (mop == 2'b00) ? mprod[XLEN-1:0] : mprod[2*XLEN-1:XLEN];
  end

  always_comb begin
    div_zero    = (req_b == '0);
    div_ovf     = ~req_op[0] & (req_a == {1'b1, {(XLEN-1){1'b0}}}) & (&req_b);
    div_special = div_zero | div_ovf;
    if (req_op[1]) special_res = div_zero ? req_a : '0;
    else           special_res = div_zero ? '1 : req_a;
  end

  restoring_divider #(
    .XLEN(XLEN)
  ) u_div (
    .clk      (clk),
    .start_i  (accept & ~op_is_mul(req_op) & ~div_special),
    .step_i   (state_q == ST_DIV),
    .signed_i (~req_op[0]),
    .a_i      (req_a),
    .b_i      (req_b),
    .quo_o    (div_quo),
    .rem_o    (div_rem)
  );

  always_ff @(posedge clk) begin
    if (accept) begin
      a_q  <= req_a;
      b_q  <= req_b;
      op_q <= req_op[1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      count_q       <= '0;
      resp_valid_q  <= 1'b0;
      resp_result_q <= '0;
      resp_rd_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            resp_rd_q <= req_rd_s;
            if (op_is_mul(req_op)) begin
              if (MUL_STAGES == 1) begin
                state_q       <= ST_DONE;
                resp_valid_q  <= 1'b1;
                resp_result_q <= mul_res;
              end else begin
                state_q <= ST_MUL;
                count_q <= CNT_W'(MUL_STAGES - 1);
              end
            end else if (div_special) begin
              state_q       <= ST_DONE;
              resp_valid_q  <= 1'b1;
              resp_result_q <= special_res;
            end else begin
              state_q <= ST_DIV;
              count_q <= CNT_W'(XLEN);
            end
          end
        end
        ST_MUL: begin
          count_q <= count_q - CNT_W'(1);
          if (flush) begin
            state_q <= ST_IDLE;
          end else if (count_q == CNT_W'(1)) begin
            state_q       <= ST_DONE;
            resp_valid_q  <= 1'b1;
            resp_result_q <= mul_res;
          end
        end
        ST_DIV: begin
          count_q <= count_q - CNT_W'(1);
          if (flush) begin
            state_q <= ST_IDLE;
          end else if (count_q == CNT_W'(1)) begin
            state_q       <= ST_DONE;
            resp_valid_q  <= 1'b1;
            resp_result_q <= op_q[1] ? div_rem : div_quo;
          end
        end
        ST_DONE: begin
          if (flush || resp_ready) begin
            state_q      <= ST_IDLE;
            resp_valid_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_muldiv.sv
// Directed bench for exec_muldiv: multiply/divide results, latencies, special
// cases, flush, backpressure and asynchronous reset.
module tb_exec_muldiv;

  localparam int XLEN = 32;
  localparam int MS   = 2;

  logic            clk;
  logic            rst_n;
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_op;
  logic [XLEN-1:0] req_a, req_b;
  logic [4:0]      req_rd_s;
  logic            flush;
  logic            busy;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_result;
  logic [4:0]      resp_rd_s;

  int checks = 0;
  int errors = 0;

  exec_muldiv #(
    .XLEN(XLEN),
    .MUL_STAGES(MS)
  ) dut (
    .clk         (clk),
    .rst         (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_rd_s    (req_rd_s),
    .flush       (flush),
    .busy        (busy),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .resp_rd_s   (resp_rd_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  mul_op  [4] = '{3'b000, 3'b001, 3'b011, 3'b010};
  logic [31:0] mul_a   [4] = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
  logic [31:0] mul_b   [4] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
  logic [31:0] mul_exp [4] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF};

  logic [2:0]  dv_op  [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
  logic [31:0] dv_a   [4] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100};
  logic [31:0] dv_b   [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
  logic [31:0] dv_exp [4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2};

  logic [2:0]  sp_op  [5] = '{3'b101, 3'b111, 3'b100, 3'b100, 3'b110};
  logic [31:0] sp_a   [5] = '{32'd5, 32'd5, 32'hFFFFFFF9, 32'h80000000, 32'h80000000};
  logic [31:0] sp_b   [5] = '{32'd0, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
  logic [31:0] sp_exp [5] = '{32'hFFFFFFFF, 32'd5, 32'hFFFFFFFF, 32'h80000000, 32'd0};

  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_rd_s  = rd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Latency counts edges from the accept edge up to the cycle resp_valid is seen.
  task automatic wait_resp(output int lat);
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic consume();
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset resp_valid: got %b expected 0", resp_valid); end
    checks++; if (resp_result !== 32'd0) begin errors++; $display("FAIL reset resp_result: got %h expected 0", resp_result); end
    checks++; if (resp_rd_s !== 5'd0) begin errors++; $display("FAIL reset resp_rd_s: got %0d expected 0", resp_rd_s); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b expected 0", busy); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset req_ready: got %b expected 1", req_ready); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_mul();
    int lat;
    for (int i = 0; i < 4; i++) begin
      send(mul_op[i], mul_a[i], mul_b[i], 5'(i + 1));
      wait_resp(lat);
      checks++; if (lat != MS) begin errors++; $display("FAIL mul[%0d] latency: got %0d expected %0d", i, lat, MS); end
      checks++; if (resp_result !== mul_exp[i]) begin errors++; $display("FAIL mul[%0d] result: got %h expected %h", i, resp_result, mul_exp[i]); end
      checks++; if (resp_rd_s !== 5'(i + 1)) begin errors++; $display("FAIL mul[%0d] tag: got %0d expected %0d", i, resp_rd_s, i + 1); end
      consume();
      checks++; if (req_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL mul[%0d] release: got ready=%b busy=%b expected ready=1 busy=0", i, req_ready, busy); end
    end
  endtask

  task automatic test_divide();
    int lat;
    for (int i = 0; i < 4; i++) begin
      send(dv_op[i], dv_a[i], dv_b[i], 5'(20 + i));
      wait_resp(lat);
      checks++; if (lat != XLEN + 1) begin errors++; $display("FAIL div[%0d] latency: got %0d expected %0d", i, lat, XLEN + 1); end
      checks++; if (resp_result !== dv_exp[i]) begin errors++; $display("FAIL div[%0d] result: got %h expected %h", i, resp_result, dv_exp[i]); end
      checks++; if (resp_rd_s !== 5'(20 + i)) begin errors++; $display("FAIL div[%0d] tag: got %0d expected %0d", i, resp_rd_s, 20 + i); end
      consume();
    end
  endtask

  task automatic test_div_special();
    int lat;
    for (int i = 0; i < 5; i++) begin
      send(sp_op[i], sp_a[i], sp_b[i], 5'(10 + i));
      wait_resp(lat);
      checks++; if (lat != 1) begin errors++; $display("FAIL special[%0d] latency: got %0d expected 1", i, lat); end
      checks++; if (resp_result !== sp_exp[i]) begin errors++; $display("FAIL special[%0d] result: got %h expected %h", i, resp_result, sp_exp[i]); end
      checks++; if (resp_rd_s !== 5'(10 + i)) begin errors++; $display("FAIL special[%0d] tag: got %0d expected %0d", i, resp_rd_s, 10 + i); end
      consume();
    end
  endtask

  task automatic test_flush();
    int lat;
    int rose;
    send(3'b100, 32'hFFFFFFF9, 32'd2, 5'd3);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    checks++; if (req_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL flush_div release: got ready=%b busy=%b expected ready=1 busy=0", req_ready, busy); end
    rose = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (resp_valid === 1'b1) rose++;
    end
    checks++; if (rose != 0) begin errors++; $display("FAIL flush_div resp_valid: got %0d valid cycles expected 0", rose); end
    send(3'b000, 32'd3, 32'd4, 5'd6);
    wait_resp(lat);
    checks++; if (lat != MS || resp_result !== 32'd12) begin errors++; $display("FAIL flush_next_mul: got lat=%0d result=%h expected lat=%0d result=0000000c", lat, resp_result, MS); end
    consume();

    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 3'b000;
    req_a     = 32'd2;
    req_b     = 32'd2;
    flush     = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    flush     = 1'b0;
    checks++; if (busy !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL flush_idle accept: got busy=%b ready=%b expected busy=0 ready=1", busy, req_ready); end
    rose = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (resp_valid === 1'b1) rose++;
    end
    checks++; if (rose != 0) begin errors++; $display("FAIL flush_idle resp_valid: got %0d valid cycles expected 0", rose); end
  endtask

  task automatic test_backpressure();
    int lat;
    send(3'b000, 32'h00001234, 32'h00000010, 5'd17);
    wait_resp(lat);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (resp_valid !== 1'b1 || resp_result !== 32'h00012340 || resp_rd_s !== 5'd17 || busy !== 1'b1) begin
        errors++;
        $display("FAIL hold[%0d]: got valid=%b result=%h tag=%0d busy=%b expected valid=1 result=00012340 tag=17 busy=1",
                 i, resp_valid, resp_result, resp_rd_s, busy);
      end
    end
    consume();
    checks++; if (busy !== 1'b0 || resp_valid !== 1'b0) begin errors++; $display("FAIL hold release: got busy=%b valid=%b expected busy=0 valid=0", busy, resp_valid); end
  endtask

  task automatic test_reset_mid_div();
    int lat;
    send(3'b101, 32'd100, 32'd7, 5'd9);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL midreset resp_valid: got %b expected 0", resp_valid); end
    checks++; if (resp_result !== 32'd0) begin errors++; $display("FAIL midreset resp_result: got %h expected 0", resp_result); end
    checks++; if (resp_rd_s !== 5'd0) begin errors++; $display("FAIL midreset resp_rd_s: got %0d expected 0", resp_rd_s); end
    checks++; if (busy !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL midreset state: got busy=%b ready=%b expected busy=0 ready=1", busy, req_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    send(3'b101, 32'd100, 32'd7, 5'd9);
    wait_resp(lat);
    checks++; if (lat != XLEN + 1 || resp_result !== 32'd14) begin errors++; $display("FAIL midreset recover: got lat=%0d result=%h expected lat=%0d result=0000000e", lat, resp_result, XLEN + 1); end
    consume();
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_op     = 3'b000;
    req_a      = '0;
    req_b      = '0;
    req_rd_s   = '0;
    flush      = 1'b0;
    resp_ready = 1'b0;

    test_reset();
    test_mul();
    test_divide();
    test_div_special();
    test_flush();
    test_backpressure();
    test_reset_mid_div();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
